serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 35 +++
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
//
// Purpose: groups the request side (start, a, b, bin) and the result side
// (busy, done, diff, bout) of one serial subtractor.
// Macro SERIAL_SUBTRACTOR_OVF_EN adds the signed-overflow flag ovf.
// Ports (signals):
//   start      request, sampled by the subtractor when it can accept
//   a, b       WIDTH-bit minuend / subtrahend
//   bin        borrow into bit 0
//   busy       operation in flight
//   done       one-cycle result-valid pulse
//   diff, bout registered result and borrow-out
//   ovf        (SERIAL_SUBTRACTOR_OVF_EN only) signed overflow of the result
// Modports: master drives the request, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle a - b - bin, DIGIT bits per clock, LSB slice first
//
// Purpose: wide unsigned subtraction using a registered borrow between
// DIGIT-bit slices; one result every STEPS+1 cycles, STEPS = WIDTH/DIGIT.
// Parameters: WIDTH >= 1 operand width; DIGIT must divide WIDTH.
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to drive bus.ovf (signed overflow).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_subtractor_if.slave: start/a/b/bin in, busy/done/diff/bout out
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             bout_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bout;
  logic             last;
  logic             accept;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
`endif

  assign last = (cnt_q == CW'(STEPS - 1));

  // The DONE exit edge doubles as an accept edge, so a held start gives
  // one operation every STEPS+1 cycles. A start seen earlier is not queued.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // Operands shift right each step, so the active slice is always in the
  // low DIGIT bits; ripple DIGIT full subtractors through it.
  always_comb begin : p_slice
    logic br;
    slice_d = '0;
    br      = br_q;
    for (int i = 0; i < DIGIT; i++) begin
      slice_d[i] = a_q[i] ^ b_q[i] ^ br;
      br         = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
    end
    slice_bout = br;
  end

  // New slice enters at the top and walks down; after STEPS steps the
  // first slice sits at bit 0.
  assign res_nxt = (res_q >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      br_q  <= bus.bin;
      res_q <= '0;
      cnt_q <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      res_q <= res_nxt;
      br_q  <= slice_bout;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        diff_q <= res_nxt;
        bout_q <= slice_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_q  <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_nxt[WIDTH-1]);
`endif
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive self-checking bench for serial_subtractor
`timescale 1ns/1ps
module tb_serial_subtractor;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       start8 = 1'b0;
  logic [7:0] a8     = 8'h00;
  logic [7:0] b8     = 8'h00;
  logic       bin8   = 1'b0;
  logic       start4 = 1'b0;
  logic [3:0] a4     = 4'h0;
  logic [3:0] b4     = 4'h0;
  logic       bin4   = 1'b0;

  serial_subtractor_if #(.WIDTH(8)) if81 ();
  serial_subtractor_if #(.WIDTH(8)) if84 ();
  serial_subtractor_if #(.WIDTH(8)) if82 ();
  serial_subtractor_if #(.WIDTH(4)) if41 ();
  serial_subtractor_if #(.WIDTH(4)) if44 ();
  serial_subtractor_if #(.WIDTH(4)) if42 ();

  assign if81.start = start8; assign if81.a = a8; assign if81.b = b8; assign if81.bin = bin8;
  assign if84.start = start8; assign if84.a = a8; assign if84.b = b8; assign if84.bin = bin8;
  assign if82.start = start8; assign if82.a = a8; assign if82.b = b8; assign if82.bin = bin8;
  assign if41.start = start4; assign if41.a = a4; assign if41.b = b4; assign if41.bin = bin4;
  assign if44.start = start4; assign if44.a = a4; assign if44.b = b4; assign if44.bin = bin4;
  assign if42.start = start4; assign if42.a = a4; assign if42.b = b4; assign if42.bin = bin4;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst_n(rst_n), .bus(if81.slave));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst_n(rst_n), .bus(if84.slave));
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u82 (.clk(clk), .rst_n(rst_n), .bus(if82.slave));
  serial_subtractor #(.WIDTH(4), .DIGIT(1)) u41 (.clk(clk), .rst_n(rst_n), .bus(if41.slave));
  serial_subtractor #(.WIDTH(4), .DIGIT(4)) u44 (.clk(clk), .rst_n(rst_n), .bus(if44.slave));
  serial_subtractor #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst_n(rst_n), .bus(if42.slave));

  // Observations from one width-8 operation, index 0/1/2 = DIGIT 1/4/2.
  int         d_at [3];
  int         b_n  [3];
  int         d_n  [3];
  logic [7:0] r_diff [3];
  logic       r_bout [3];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       r_ovf  [3];
`endif

  task automatic note(input int i, input logic busy, input logic done, input int n);
    if (busy === 1'b1) b_n[i]++;
    if (done === 1'b1) begin
      d_n[i]++;
      if (d_at[i] < 0) d_at[i] = n;
    end
  endtask

  // One width-8 operation; operands are scrambled right after the accept edge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
    @(posedge clk); #1;
    a8 = ta; b8 = tb_v; bin8 = tbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~ta; b8 = ~tb_v; bin8 = ~tbin;
    for (int i = 0; i < 3; i++) begin
      d_at[i] = -1; b_n[i] = 0; d_n[i] = 0;
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      note(0, if81.busy, if81.done, n);
      note(1, if84.busy, if84.done, n);
      note(2, if82.busy, if82.done, n);
    end
    r_diff[0] = if81.diff; r_bout[0] = if81.bout;
    r_diff[1] = if84.diff; r_bout[1] = if84.bout;
    r_diff[2] = if82.diff; r_bout[2] = if82.bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    r_ovf[0] = if81.ovf; r_ovf[1] = if84.ovf; r_ovf[2] = if82.ovf;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({if81.busy, if81.done, if81.diff, if81.bout} !== 11'b0) begin bad++; $display("FAIL reset d1: got %b want 0", {if81.busy, if81.done, if81.diff, if81.bout}); end
    total++; if ({if84.busy, if84.done, if84.diff, if84.bout} !== 11'b0) begin bad++; $display("FAIL reset d4: got %b want 0", {if84.busy, if84.done, if84.diff, if84.bout}); end
    total++; if ({if82.busy, if82.done, if82.diff, if82.bout} !== 11'b0) begin bad++; $display("FAIL reset d2: got %b want 0", {if82.busy, if82.done, if82.diff, if82.bout}); end
    total++; if ({if41.busy, if41.done, if41.diff, if41.bout} !== 7'b0) begin bad++; $display("FAIL reset w4d1: got %b want 0", {if41.busy, if41.done, if41.diff, if41.bout}); end
    total++; if ({if44.busy, if44.done, if44.diff, if44.bout} !== 7'b0) begin bad++; $display("FAIL reset w4d4: got %b want 0", {if44.busy, if44.done, if44.diff, if44.bout}); end
    total++; if ({if42.busy, if42.done, if42.diff, if42.bout} !== 7'b0) begin bad++; $display("FAIL reset w4d2: got %b want 0", {if42.busy, if42.done, if42.diff, if42.bout}); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    total++; if ({if81.ovf, if84.ovf, if82.ovf} !== 3'b0) begin bad++; $display("FAIL reset ovf: got %b want 000", {if81.ovf, if84.ovf, if82.ovf}); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] va   [5] = '{8'h5A, 8'h00, 8'h80, 8'h37, 8'h00};
    logic [7:0] vb   [5] = '{8'h3C, 8'h01, 8'h01, 8'h37, 8'hFF};
    logic       vbin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ed   [5] = '{8'h1E, 8'hFF, 8'h7F, 8'hFF, 8'h00};
    logic       eb   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       eo   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    int         steps [3] = '{8, 2, 4};
    string      nm    [3] = '{"d1", "d4", "d2"};
    for (int v = 0; v < 5; v++) begin
      run8(va[v], vb[v], vbin[v]);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (d_at[i] !== steps[i] || b_n[i] !== steps[i] || d_n[i] !== 1) begin
          bad++;
          $display("FAIL vec%0d %s timing: done_at=%0d busy_cycles=%0d dones=%0d want %0d/%0d/1",
                   v, nm[i], d_at[i], b_n[i], d_n[i], steps[i], steps[i]);
        end
        total++;
        if ({r_bout[i], r_diff[i]} !== {eb[v], ed[v]}) begin
          bad++;
          $display("FAIL vec%0d %s result: bout=%b diff=%h want bout=%b diff=%h",
                   v, nm[i], r_bout[i], r_diff[i], eb[v], ed[v]);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        total++;
        if (r_ovf[i] !== eo[v]) begin
          bad++;
          $display("FAIL vec%0d %s ovf: got %b want %b", v, nm[i], r_ovf[i], eo[v]);
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [3] = '{8'h5A, 8'hC8, 8'h10};
    logic [7:0] ob [3] = '{8'h3C, 8'h64, 8'h20};
    logic [7:0] ed [3] = '{8'h1E, 8'h64, 8'hF0};
    logic       eb [3] = '{1'b0, 1'b0, 1'b1};
    logic       exp_done;
    @(posedge clk); #1;
    a8 = oa[0]; b8 = ob[0]; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 27; n++) begin
      if (n % 9 == 8) begin
        if (n == 26) start8 = 1'b0;
        else begin a8 = oa[(n + 1) / 9]; b8 = ob[(n + 1) / 9]; end
      end else begin
        a8 = 8'hFF; b8 = 8'h00;
      end
      @(negedge clk);
      exp_done = (n % 9 == 8);
      total++;
      if ({if81.busy, if81.done} !== {~exp_done, exp_done}) begin
        bad++;
        $display("FAIL b2b cycle%0d busy/done: got %b%b want %b%b", n, if81.busy, if81.done, ~exp_done, exp_done);
      end
      if (exp_done) begin
        total++;
        if ({if81.bout, if81.diff} !== {eb[n / 9], ed[n / 9]}) begin
          bad++;
          $display("FAIL b2b op%0d result: bout=%b diff=%h want bout=%b diff=%h",
                   n / 9, if81.bout, if81.diff, eb[n / 9], ed[n / 9]);
        end
      end
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_async_reset();
    int dones;
    int busys;
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (if81.busy !== 1'b1) begin bad++; $display("FAIL arst pre busy: got %b want 1", if81.busy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({if81.busy, if81.done, if81.diff, if81.bout} !== 11'b0) begin bad++; $display("FAIL arst d1: got %b want 0", {if81.busy, if81.done, if81.diff, if81.bout}); end
    total++; if ({if84.busy, if84.done, if84.diff, if84.bout} !== 11'b0) begin bad++; $display("FAIL arst d4: got %b want 0", {if84.busy, if84.done, if84.diff, if84.bout}); end
    total++; if ({if82.busy, if82.done, if82.diff, if82.bout} !== 11'b0) begin bad++; $display("FAIL arst d2: got %b want 0", {if82.busy, if82.done, if82.diff, if82.bout}); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    dones = 0; busys = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      dones += int'(if81.done) + int'(if84.done) + int'(if82.done);
      busys += int'(if81.busy) + int'(if84.busy) + int'(if82.busy);
    end
    total++; if (dones !== 0 || busys !== 0) begin bad++; $display("FAIL arst idle after release: dones=%0d busy_cycles=%0d want 0/0", dones, busys); end
    run8(8'hC8, 8'h64, 1'b0);
    total++;
    if (d_n[0] !== 1 || {r_bout[0], r_diff[0]} !== {1'b0, 8'h64}) begin
      bad++;
      $display("FAIL arst recovery: dones=%0d bout=%b diff=%h want 1 0 64", d_n[0], r_bout[0], r_diff[0]);
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] m;
    int         dn [3];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       mo;
`endif
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(posedge clk); #1;
          a4 = 4'(ia); b4 = 4'(ib); bin4 = ic[0]; start4 = 1'b1;
          m = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          mo = (a4[3] ^ b4[3]) & (a4[3] ^ m[3]);
`endif
          @(posedge clk); #1;
          start4 = 1'b0; a4 = ~a4; b4 = ~b4; bin4 = ~bin4;
          dn[0] = 0; dn[1] = 0; dn[2] = 0;
          for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            dn[0] += int'(if41.done); dn[1] += int'(if44.done); dn[2] += int'(if42.done);
          end
          total++;
          if (dn[0] !== 1 || dn[1] !== 1 || dn[2] !== 1) begin
            bad++;
            $display("FAIL exh a=%0d b=%0d bin=%0d dones: %0d/%0d/%0d want 1/1/1", ia, ib, ic, dn[0], dn[1], dn[2]);
          end
          total++; if ({if41.bout, if41.diff} !== m) begin bad++; $display("FAIL exh d1 a=%0d b=%0d bin=%0d: got %b want %b", ia, ib, ic, {if41.bout, if41.diff}, m); end
          total++; if ({if44.bout, if44.diff} !== m) begin bad++; $display("FAIL exh d4 a=%0d b=%0d bin=%0d: got %b want %b", ia, ib, ic, {if44.bout, if44.diff}, m); end
          total++; if ({if42.bout, if42.diff} !== m) begin bad++; $display("FAIL exh d2 a=%0d b=%0d bin=%0d: got %b want %b", ia, ib, ic, {if42.bout, if42.diff}, m); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          total++;
          if ({if41.ovf, if44.ovf, if42.ovf} !== {3{mo}}) begin
            bad++;
            $display("FAIL exh ovf a=%0d b=%0d bin=%0d: got %b want %b", ia, ib, ic, {if41.ovf, if44.ovf, if42.ovf}, {3{mo}});
          end
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
